clk_div_monitor: RTL and testbench



---
 rtl/clk_div_monitor.sv | 133 +++++++++++++
 tb/tb_clk_div_monitor.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_monitor.sv
// Monitors a divided clock derived from clk: measures its period and high time,
// declares lock after a run of periods equal to N, and flags bad periods or a stuck input.
module clk_div_monitor #(
  parameter int N        = 7,
  parameter int LOCK_CNT = 4,
  parameter int W        = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         div_in,
  input  logic         clr_err,
  output logic [W-1:0] period,
  output logic [W-1:0] high_time,
  output logic         meas_valid,
  output logic         locked,
  output logic         err
);

  localparam int             GW       = $clog2(LOCK_CNT + 1);
  localparam logic [W-1:0]   CNT_MAX  = {W{1'b1}};
  localparam logic [W-1:0]   N_VAL    = W'(N);
  localparam logic [W-1:0]   TIMEOUT  = W'(2 * N);
  localparam logic [GW-1:0]  GOOD_MAX = GW'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          d1, d2;
  logic          rise;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]  hcnt_q, hcnt_d;
  logic [GW-1:0] good_q, good_d;
  logic          meas_evt;
  logic          err_evt;

  assign rise   = d1 & ~d2;
  assign locked = (state_q == LOCKED);

  // Next-state and event decode. A rise always takes precedence over the timeout.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d  = state_q;
    good_d   = good_q;
    meas_evt = 1'b0;
    err_evt  = 1'b0;
    if (!en) begin
      state_d = IDLE;
      good_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) state_d = MEASURE;
        end
        MEASURE, LOCKED: begin
          if (rise) begin
            meas_evt = 1'b1;
            if (cnt_q == N_VAL) begin
              if (good_q >= GOOD_MAX - GW'(1)) begin
                good_d  = GOOD_MAX;
                state_d = LOCKED;
              end else begin
                good_d = good_q + GW'(1);
              end
            end else begin
              err_evt = 1'b1;
              good_d  = '0;
              state_d = MEASURE;
            end
          end else if (cnt_q == TIMEOUT) begin
            err_evt = 1'b1;
            good_d  = '0;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          good_d  = '0;
        end
      endcase
    end
  end

  // Counters sit at zero whenever the monitor is (or is about to be) idle.
  always_comb begin
    cnt_d  = cnt_q;
    hcnt_d = hcnt_q;
    if (state_d == IDLE) begin
      cnt_d  = '0;
      hcnt_d = '0;
    end else if (rise) begin
      cnt_d  = W'(1);
      hcnt_d = W'(1);
    end else begin
      if (cnt_q != CNT_MAX)           cnt_d  = cnt_q + W'(1);
      if (d1 && (hcnt_q != CNT_MAX))  hcnt_d = hcnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      d1         <= 1'b0;
      d2         <= 1'b0;
      cnt_q      <= '0;
      hcnt_q     <= '0;
      good_q     <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      d1         <= div_in;
      d2         <= d1;
      cnt_q      <= cnt_d;
      hcnt_q     <= hcnt_d;
      good_q     <= good_d;
      meas_valid <= meas_evt;
      err        <= err_evt | (err & ~clr_err);
      if (meas_evt) begin
        period    <= cnt_q;
        high_time <= hcnt_q;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: directed scenarios plus randomized periods, all checked
// every cycle against an edge-history model of the divided clock.
module tb_clk_div_monitor;

  localparam int N        = 7;
  localparam int LOCK_CNT = 4;
  localparam int W        = 8;
  localparam int MAXC     = 16384;

  logic         clk;
  logic         rst;
  logic         en;
  logic         div_in;
  logic         clr_err;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         meas_valid;
  logic         locked;
  logic         err;

  int errors = 0;
  int checks = 0;

  clk_div_monitor #(.N(N), .LOCK_CNT(LOCK_CNT), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .div_in     (div_in),
    .clr_err    (clr_err),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .locked     (locked),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: history of div_in samples indexed by clock edge. A rise is acted on two
  // edges after the input is first sampled high; period is the edge distance between
  // acted rises, high time the number of high samples inside that window.
  typedef struct packed {
    bit active;
    int e;
    int good;
    bit locked;
    bit err;
    int period;
    int ht;
    bit mv;
  } model_t;

  model_t m = '0;
  bit     lvl [MAXC];
  int     k     = 0;
  int     rbase = 0;

  function automatic bit lv(input int j);
    if (j < rbase || j < 0 || j >= MAXC) return 1'b0;
    return lvl[j];
  endfunction

  function automatic model_t step(input model_t s, input int kk, input bit en_v, input bit clr_v);
    model_t n = s;
    bit rise_v;
    bit err_evt = 1'b0;
    rise_v = lv(kk - 1) && !lv(kk - 2);
    n.mv = 1'b0;
    if (!en_v) begin
      n.active = 1'b0;
      n.good   = 0;
      n.locked = 1'b0;
    end else if (!s.active) begin
      if (rise_v) begin
        n.active = 1'b1;
        n.e      = kk;
      end
    end else if (rise_v) begin
      n.period = kk - s.e;
      n.ht     = 0;
      for (int j = s.e - 1; j <= kk - 2; j++) n.ht += int'(lv(j));
      n.mv = 1'b1;
      n.e  = kk;
      if (n.period == N) begin
        n.good = (s.good + 1 > LOCK_CNT) ? LOCK_CNT : s.good + 1;
        if (n.good == LOCK_CNT) n.locked = 1'b1;
      end else begin
        err_evt  = 1'b1;
        n.good   = 0;
        n.locked = 1'b0;
      end
    end else if (kk - s.e == 2 * N) begin
      err_evt  = 1'b1;
      n.active = 1'b0;
      n.good   = 0;
      n.locked = 1'b0;
    end
    n.err = err_evt || (s.err && !clr_v);
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m     <= '0;
      rbase <= k;
    end else begin
      m <= step(m, k, en, clr_err);
      if (k < MAXC) lvl[k] <= div_in;
      k <= k + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("period",     32'(period),     32'(m.period));
    check("high_time",  32'(high_time),  32'(m.ht));
    check("meas_valid", 32'(meas_valid), 32'(m.mv));
    check("locked",     32'(locked),     32'(m.locked));
    check("err",        32'(err),        32'(m.err));
  endtask

  // Each tick compares at the falling edge, then advances to 2 time units past the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      compare_model();
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive_period(input int hi, input int lo);
    div_in = 1'b1;
    tick(hi);
    div_in = 1'b0;
    tick(lo);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_period"},     32'(period),     32'd0);
    check({tag, "_high_time"},  32'(high_time),  32'd0);
    check({tag, "_meas_valid"}, 32'(meas_valid), 32'd0);
    check({tag, "_locked"},     32'(locked),     32'd0);
    check({tag, "_err"},        32'(err),        32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    div_in  = 1'b0;
    clr_err = 1'b0;
    tick(3);
    check_all_zero("reset");
    rst = 1'b0;
    en  = 1'b1;
    tick(2);

    // Steady 3-high/4-low divider: first rise arms, lock on the 4th measured period.
    repeat (4) drive_period(3, 4);
    check("steady_not_yet_locked", 32'(locked), 32'd0);
    drive_period(3, 4);
    check("steady_locked", 32'(locked), 32'd1);
    repeat (2) drive_period(3, 4);
    check("steady_period", 32'(period),    32'd7);
    check("steady_high",   32'(high_time), 32'd3);
    check("steady_err",    32'(err),       32'd0);

    // One short period while locked, then relock with the error left sticky.
    drive_period(3, 3);
    drive_period(3, 4);
    check("glitch_period", 32'(period), 32'd6);
    check("glitch_err",    32'(err),    32'd1);
    check("glitch_locked", 32'(locked), 32'd0);
    repeat (4) drive_period(3, 4);
    check("relock_locked", 32'(locked), 32'd1);
    check("relock_err",    32'(err),    32'd1);

    // clr_err coinciding with a bad-period rise leaves err set.
    drive_period(3, 2);
    div_in  = 1'b1;
    tick(1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    tick(1);
    div_in  = 1'b0;
    tick(4);
    check("collide_period", 32'(period), 32'd5);
    check("collide_err",    32'(err),    32'd1);
    repeat (5) drive_period(3, 4);
    check("collide_relock", 32'(locked), 32'd1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("clear_alone_err", 32'(err), 32'd0);

    // Stuck-low input while locked times out to idle.
    tick(20);
    check("stuck_err",    32'(err),        32'd1);
    check("stuck_locked", 32'(locked),     32'd0);
    check("stuck_mv",     32'(meas_valid), 32'd0);
    check("stuck_period", 32'(period),     32'd7);

    // Reset while locked clears every output at once.
    repeat (6) drive_period(3, 4);
    check("prereset_locked", 32'(locked), 32'd1);
    div_in = 1'b1;
    tick(1);
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    div_in = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(2);
    drive_period(3, 4);
    check("post_reset_first_rise", 32'(period), 32'd0);
    drive_period(3, 4);
    check("post_reset_second_rise", 32'(period), 32'd7);
    check("post_reset_err",         32'(err),    32'd0);

    // Enable drop while locked; relock needs an arming rise plus four good periods.
    repeat (5) drive_period(3, 4);
    check("pre_drop_locked", 32'(locked), 32'd1);
    en = 1'b0;
    tick(10);
    check("drop_locked", 32'(locked), 32'd0);
    check("drop_period", 32'(period), 32'd7);
    en = 1'b1;
    repeat (4) drive_period(3, 4);
    check("reenable_not_locked", 32'(locked), 32'd0);
    drive_period(3, 4);
    check("reenable_locked", 32'(locked), 32'd1);

    // Randomized periods with sporadic clears, enable drops, resets and stalls.
    for (int it = 0; it < 300; it++) begin
      int hi, lo, r;
      r  = int'($urandom_range(0, 99));
      hi = int'($urandom_range(1, N - 1));
      if (r < 60)      lo = N - hi;
      else if (r < 90) lo = int'($urandom_range(1, N));
      else             lo = int'($urandom_range(N, 2 * N + 3));
      if ($urandom_range(0, 49) == 0) begin
        en = 1'b0;
        tick(int'($urandom_range(1, 5)));
        en = 1'b1;
      end
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
      end
      div_in = 1'b1;
      for (int c = 0; c < hi; c++) begin
        clr_err = ($urandom_range(0, 19) == 0);
        tick(1);
      end
      div_in = 1'b0;
      for (int c = 0; c < lo; c++) begin
        clr_err = ($urandom_range(0, 19) == 0);
        tick(1);
      end
      clr_err = 1'b0;
    end
    tick(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
